// File: rtl/hls_deadlock_pkg.sv
// hls_deadlock_pkg: shared FSM states and report counter type for the deadlock report controller
package hls_deadlock_pkg;
   typedef enum logic [2:0] {IDLE, ARMED, QUALIFY, REPORT, COOLDOWN} state_t;
   localparam int CNT_W = 16;
   typedef logic [CNT_W-1:0] count_t;
endpackage

// File: rtl/hls_deadlock_report_ctrl_if.sv
// hls_deadlock_report_ctrl_if: deadlock report valid/ready channel carrying the blamed mask and index
interface hls_deadlock_report_ctrl_if #(parameter int NUM_MON = 4);
   localparam int ID_W = $clog2(NUM_MON);
   logic dl_valid;
   logic dl_ready;
   logic [NUM_MON-1:0] dl_mask;
   logic [ID_W-1:0] dl_id;
   modport master(output dl_valid, dl_mask, dl_id, input dl_ready);
   modport slave(input dl_valid, dl_mask, dl_id, output dl_ready);
endinterface

// File: rtl/hls_deadlock_rr_pick.sv
// hls_deadlock_rr_pick: first set bit of mask scanning upward from ptr, wrapping to 0
module hls_deadlock_rr_pick #(
   parameter int NUM_MON = 4,
   localparam int ID_W = $clog2(NUM_MON)
) (
   input  logic [NUM_MON-1:0] mask,
   input  logic [ID_W-1:0]    ptr,
   output logic [ID_W-1:0]    index
);
   logic            found;
   logic [ID_W-1:0] j;
   // walk the monitors in rotated order and keep the first one that is blocked
   always_comb begin
      index = '0;
      found = 1'b0;
      j = '0;
      for (int i = 0; i < NUM_MON; i++) begin
         j = ID_W'((int'(ptr) + i) % NUM_MON);
         if (!found && mask[j]) begin
            index = j;
            found = 1'b1;
         end
      end
   end
endmodule

// File: rtl/hls_deadlock_report_ctrl.sv
// hls_deadlock_report_ctrl: qualifies sustained monitor blocking and issues one round-robin deadlock report
module hls_deadlock_report_ctrl
   import hls_deadlock_pkg::*;
#(
   parameter int NUM_MON = 4,
   parameter int HOLD_CYCLES = 16
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               enable,
   input  logic [NUM_MON-1:0] mon_block,
   output count_t             dl_count,
   output logic               busy,
   hls_deadlock_report_ctrl_if.master dl
);
   localparam int ID_W = $clog2(NUM_MON);
   localparam int HW = $clog2(HOLD_CYCLES + 1);
   state_t             state_q, state_d;
   logic [HW-1:0]      hold_q, hold_d;
   logic [NUM_MON-1:0] mask_q, mask_d;
   logic [ID_W-1:0]    id_q, id_d, rr_q, rr_d, pick;
   count_t             count_q, count_d;
   logic               any, fire, valid;
   assign any = |mon_block;
   assign fire = (state_q == REPORT) && dl.dl_ready;
   assign dl.dl_valid = valid;
   assign dl.dl_mask = mask_q;
   assign dl.dl_id = id_q;
   assign dl_count = count_q;
   hls_deadlock_rr_pick #(.NUM_MON(NUM_MON)) u_pick (
      .mask  (mon_block),
      .ptr   (rr_q),
      .index (pick)
   );
   // state and datapath registers; reset also drops any pending report uncounted
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         hold_q  <= '0;
         mask_q  <= '0;
         id_q    <= '0;
         rr_q    <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         mask_q  <= mask_d;
         id_q    <= id_d;
         rr_q    <= rr_d;
         count_q <= count_d;
      end
   end
   // next state and consecutive-blocked-cycle counter; a report always completes before disarming
   always_comb begin
      state_d = state_q;
      hold_d = hold_q;
      case (state_q)
         IDLE: begin
            hold_d = '0;
            if (enable) state_d = ARMED;
         end
         ARMED: begin
            if (!enable) state_d = IDLE;
            else if (any) begin
               state_d = QUALIFY;
               hold_d = HW'(1);
            end
         end
         QUALIFY: begin
            if (!enable || !any) begin
               state_d = enable ? ARMED : IDLE;
               hold_d = '0;
            end else if (hold_q == HW'(HOLD_CYCLES - 1)) begin
               state_d = REPORT;
               hold_d = '0;
            end else hold_d = hold_q + HW'(1);
         end
         REPORT: if (fire) state_d = enable ? COOLDOWN : IDLE;
         COOLDOWN: begin
            if (!enable) state_d = IDLE;
            else if (!any) state_d = ARMED;
         end
         default: begin
            state_d = IDLE;
            hold_d = '0;
         end
      endcase
   end
   // outputs plus report snapshot, round-robin pointer advance and saturating acceptance count
   always_comb begin
      valid = state_q == REPORT;
      busy = state_q != IDLE;
      mask_d = (state_q == QUALIFY && state_d == REPORT) ? mon_block : mask_q;
      id_d = (state_q == QUALIFY && state_d == REPORT) ? pick : id_q;
      count_d = (fire && count_q != '1) ? count_q + count_t'(1) : count_q;
      rr_d = fire ? ((id_q == ID_W'(NUM_MON - 1)) ? '0 : id_q + ID_W'(1)) : rr_q;
   end
endmodule

// File: tb/tb_hls_deadlock_report_ctrl.sv
// tb_hls_deadlock_report_ctrl: directed scoreboard bench for the deadlock report controller
module tb_hls_deadlock_report_ctrl;
   typedef struct {
      logic [3:0] mask;
      logic [1:0] id;
   } exp_t;
   logic        clock = 1'b0;
   logic        reset, enable;
   logic [3:0]  mon_block;
   logic [15:0] dl_count;
   logic        busy;
   int          errors = 0;
   int          checks = 0;
   exp_t        sb[$];
   exp_t        e;
   hls_deadlock_report_ctrl_if #(.NUM_MON(4)) dl();
   hls_deadlock_report_ctrl #(.NUM_MON(4), .HOLD_CYCLES(16)) dut (
      .clock     (clock),
      .reset     (reset),
      .enable    (enable),
      .mon_block (mon_block),
      .dl_count  (dl_count),
      .busy      (busy),
      .dl        (dl)
   );
   always #5 clock = ~clock;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic tick(input int n = 1);
      repeat (n) @(posedge clock);
      #1;
   endtask
   // scoreboard: every accepted report must match the oldest expected one
   always @(negedge clock) begin
      if (!reset && dl.dl_valid && dl.dl_ready) begin
         if (sb.size() == 0) chk("unexpected_report", 32'd1, 32'd0);
         else begin
            e = sb.pop_front();
            chk("sb_mask", 32'(dl.dl_mask), 32'(e.mask));
            chk("sb_id", 32'(dl.dl_id), 32'(e.id));
         end
      end
   end
   initial begin
      logic [1:0] rr_ids [3];
      rr_ids = '{2'd0, 2'd1, 2'd3};
      reset = 1'b1;
      enable = 1'b0;
      mon_block = 4'b0;
      dl.dl_ready = 1'b0;
      tick(2);
      reset = 1'b0;
      chk("rst_valid", 32'(dl.dl_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_count", 32'(dl_count), 0);
      chk("rst_mask", 32'(dl.dl_mask), 0);
      chk("rst_id", 32'(dl.dl_id), 0);
      // single blocked monitor, exact latency
      enable = 1'b1;
      dl.dl_ready = 1'b1;
      tick();
      chk("armed_busy", 32'(busy), 1);
      mon_block = 4'b0100;
      sb.push_back('{4'b0100, 2'd2});
      tick(15);
      chk("lat_early", 32'(dl.dl_valid), 0);
      tick();
      chk("lat_valid", 32'(dl.dl_valid), 1);
      chk("lat_id", 32'(dl.dl_id), 2);
      chk("lat_mask", 32'(dl.dl_mask), 32'b0100);
      tick();
      chk("cnt1", 32'(dl_count), 1);
      chk("cooldown_valid", 32'(dl.dl_valid), 0);
      mon_block = 4'b0;
      tick();
      // interrupted blocking restarts qualification
      mon_block = 4'b0001;
      tick(10);
      mon_block = 4'b0;
      tick();
      chk("gap_valid", 32'(dl.dl_valid), 0);
      chk("gap_busy", 32'(busy), 1);
      mon_block = 4'b0001;
      sb.push_back('{4'b0001, 2'd0});
      tick(15);
      chk("restart_early", 32'(dl.dl_valid), 0);
      tick();
      chk("restart_valid", 32'(dl.dl_valid), 1);
      tick();
      chk("cnt2", 32'(dl_count), 2);
      mon_block = 4'b0;
      tick();
      // round-robin rotation from a fresh pointer
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rst2_count", 32'(dl_count), 0);
      tick();
      for (int k = 0; k < 3; k++) begin
         mon_block = 4'b1011;
         sb.push_back('{4'b1011, rr_ids[k]});
         tick(16);
         chk("rr_valid", 32'(dl.dl_valid), 1);
         chk("rr_id", 32'(dl.dl_id), 32'(rr_ids[k]));
         tick();
         chk("rr_count", 32'(dl_count), 32'(k + 1));
         if (k == 0) begin
            tick(4);
            chk("cool_hold_valid", 32'(dl.dl_valid), 0);
            chk("cool_hold_busy", 32'(busy), 1);
         end
         mon_block = 4'b0;
         tick();
      end
      // backpressure with mon_block changing under a pending report
      dl.dl_ready = 1'b0;
      mon_block = 4'b0100;
      sb.push_back('{4'b0100, 2'd2});
      tick(16);
      for (int i = 0; i < 5; i++) begin
         mon_block = i[0] ? 4'b0001 : 4'b1111;
         tick();
         chk("bp_valid", 32'(dl.dl_valid), 1);
         chk("bp_mask", 32'(dl.dl_mask), 32'b0100);
         chk("bp_id", 32'(dl.dl_id), 2);
      end
      chk("bp_count_pre", 32'(dl_count), 3);
      dl.dl_ready = 1'b1;
      tick();
      chk("bp_count_post", 32'(dl_count), 4);
      chk("bp_valid_post", 32'(dl.dl_valid), 0);
      mon_block = 4'b0;
      tick();
      // reset while a report is pending discards it
      dl.dl_ready = 1'b0;
      mon_block = 4'b1000;
      tick(16);
      chk("pend_valid", 32'(dl.dl_valid), 1);
      chk("pend_id", 32'(dl.dl_id), 3);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mid_rst_valid", 32'(dl.dl_valid), 0);
      chk("mid_rst_count", 32'(dl_count), 0);
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_id", 32'(dl.dl_id), 0);
      // disable during qualification aborts without reporting
      dl.dl_ready = 1'b1;
      mon_block = 4'b0;
      tick();
      mon_block = 4'b0001;
      tick(5);
      enable = 1'b0;
      tick();
      chk("dis_busy", 32'(busy), 0);
      tick(20);
      chk("dis_valid", 32'(dl.dl_valid), 0);
      chk("dis_count", 32'(dl_count), 0);
      chk("sb_drained", 32'(sb.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
